// File: rtl/multdiv_defs_pkg.sv
// rtl/multdiv_defs_pkg.sv - shared state encodings, step counts and helpers for multdiv_unit
package multdiv_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MULT = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    localparam int              CNT_W      = 6;
    localparam logic [CNT_W-1:0] MULT_STEPS = 6'd16;
    localparam logic [CNT_W-1:0] DIV_STEPS  = 6'd32;

    // Magnitude of a two's complement word; 0x80000000 maps to 2^31 as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/addsub33.sv
// rtl/addsub33.sv - 33-bit adder/subtractor shared by Booth accumulate and division trial subtract
// Ports:
//   a, b  : 33-bit operands
//   sub   : 1 selects a - b, 0 selects a + b
//   sum   : 33-bit result
//   cout  : carry out of bit 32 (for subtract, 1 means no borrow)
module addsub33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        cout
);

    logic [33:0] full;

    assign full = {1'b0, a} + {1'b0, b ^ {33{sub}}} + {33'd0, sub};
    assign sum  = full[32:0];
    assign cout = full[33];

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - multicycle signed multiply (radix-4 Booth) / divide (restoring) unit
// Ports:
//   clk, reset (sync, active-low)
//   ctrl_MULT, ctrl_DIV           : start pulses, MULT wins when both are high
//   data_operandA, data_operandB  : multiplicand/dividend, multiplier/divisor
//   in_IR                         : instruction word latched at start
//   data_result, data_exception   : result and overflow/div-by-zero flag, held until next result
//   data_resultRDY                : one-cycle valid pulse in DONE
//   out_IR                        : instruction word of the operation in flight / last finished
//   busy                          : high while iterating (MULT or DIV)
module multdiv_unit
    import multdiv_defs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [31:0] in_IR,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic [31:0] out_IR,
    output logic        busy
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // hi holds the Booth upper accumulator or the division remainder;
    // lo holds the multiplier / dividend, shifted out as product / quotient bits shift in.
    logic [32:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               qm1_q, qm1_d;
    // Multiplicand for MULT, divisor magnitude for DIV.
    logic [31:0]        opa_q, opa_d;
    logic               neg_q, neg_d;
    logic               div0_q, div0_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        result_q, result_d;
    logic               exc_q, exc_d;
    logic [31:0]        ir_q, ir_d;

    logic [32:0]        add_a, add_b, add_sum;
    logic               add_sub, add_cout;
    logic [33:0]        sum34;
    logic [2:0]         booth;
    logic [32:0]        mul_hi_n, div_rem_n, rem_shift;
    logic [31:0]        mul_lo_n, div_lo_n, quot_signed;

    addsub33 u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        booth     = {lo_q[1:0], qm1_q};
        rem_shift = {hi_q[31:0], lo_q[31]};
        add_a     = hi_q;
        add_b     = 33'd0;
        add_sub   = 1'b0;
        if (state_q == ST_DIV) begin
            add_a   = rem_shift;
            add_b   = {1'b0, opa_q};
            add_sub = 1'b1;
        end else begin
            unique case (booth)
                3'b001, 3'b010: begin add_b = {opa_q[31], opa_q}; add_sub = 1'b0; end
                3'b011:         begin add_b = {opa_q, 1'b0};      add_sub = 1'b0; end
                3'b100:         begin add_b = {opa_q, 1'b0};      add_sub = 1'b1; end
                3'b101, 3'b110: begin add_b = {opa_q[31], opa_q}; add_sub = 1'b1; end
                default:        begin add_b = 33'd0;              add_sub = 1'b0; end
            endcase
        end

        // Signed 34-bit view of the sum: the extra bit is recovered from the
        // operand signs and the carry, since +/-2A plus the accumulator can need it.
        sum34    = {add_a[32] ^ add_b[32] ^ add_sub ^ add_cout, add_sum};
        mul_hi_n = {sum34[33], sum34[33:2]};
        mul_lo_n = {sum34[1:0], lo_q[31:2]};

        div_rem_n   = add_cout ? add_sum : rem_shift;
        div_lo_n    = {lo_q[30:0], add_cout};
        quot_signed = neg_q ? (~div_lo_n + 32'd1) : div_lo_n;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        opa_d    = opa_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        ir_d     = ir_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (ctrl_MULT) begin
                    state_d = ST_MULT;
                    cnt_d   = '0;
                    hi_d    = 33'd0;
                    lo_d    = data_operandB;
                    qm1_d   = 1'b0;
                    opa_d   = data_operandA;
                    ir_d    = in_IR;
                end else if (ctrl_DIV) begin
                    state_d = ST_DIV;
                    cnt_d   = '0;
                    hi_d    = 33'd0;
                    lo_d    = abs32(data_operandA);
                    qm1_d   = 1'b0;
                    opa_d   = abs32(data_operandB);
                    neg_d   = data_operandA[31] ^ data_operandB[31];
                    div0_d  = (data_operandB == 32'd0);
                    ovf_d   = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
                    ir_d    = in_IR;
                end
            end
            ST_MULT: begin
                hi_d  = mul_hi_n;
                lo_d  = mul_lo_n;
                qm1_d = lo_q[1];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == MULT_STEPS - 6'd1) begin
                    state_d  = ST_DONE;
                    result_d = mul_lo_n;
                    exc_d    = (mul_hi_n[31:0] != {32{mul_lo_n[31]}});
                end
            end
            ST_DIV: begin
                hi_d  = div_rem_n;
                lo_d  = div_lo_n;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == DIV_STEPS - 6'd1) begin
                    state_d  = ST_DONE;
                    // Divide-by-zero still runs the full 32 steps; the quotient is discarded here.
                    result_d = div0_q ? 32'd0 : quot_signed;
                    exc_d    = div0_q | ovf_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            opa_q    <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            ir_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            opa_q    <= opa_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            ir_q     <= ir_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign out_IR         = ir_q;
    assign data_resultRDY = (state_q == ST_DONE);
    assign busy           = (state_q == ST_MULT) || (state_q == ST_DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - self-checking bench for multdiv_unit against an arithmetic reference model
module tb_multdiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] in_IR = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic [31:0] out_IR;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_res, exp_ir;
    logic        exp_exc;
    int          exp_lat;

    multdiv_unit dut (
        .clk            (clk),
        .reset          (rst_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .in_IR          (in_IR),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .out_IR         (out_IR),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a start request and records the expected outcome from plain signed arithmetic.
    task automatic start_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ir);
        longint p, q;
        ctrl_MULT     = is_mul;
        ctrl_DIV      = !is_mul;
        data_operandA = a;
        data_operandB = b;
        in_IR         = ir;
        exp_ir        = ir;
        if (is_mul) begin
            p       = longint'($signed(a)) * longint'($signed(b));
            exp_res = p[31:0];
            exp_exc = (p != longint'($signed(p[31:0])));
            exp_lat = 17;
        end else begin
            exp_lat = 33;
            if (b == 32'd0) begin
                exp_res = 32'd0;
                exp_exc = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                exp_res = 32'h8000_0000;
                exp_exc = 1'b1;
            end else begin
                q       = longint'($signed(a)) / longint'($signed(b));
                exp_res = q[31:0];
                exp_exc = 1'b0;
            end
        end
    endtask

    // Clocks edge E0, then waits for the result pulse and checks it. inject_cyc > 0
    // raises a stray ctrl_MULT during that busy cycle.
    task automatic wait_done(input string tag, input int inject_cyc);
        int cyc;
        int busy_low;
        tick();
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        in_IR         = $urandom;
        cyc      = 1;
        busy_low = 0;
        while (!data_resultRDY && cyc < 60) begin
            if (!busy) busy_low++;
            if (cyc == inject_cyc) ctrl_MULT = 1'b1;
            tick();
            ctrl_MULT = 1'b0;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " busy_gaps"}, 64'(busy_low), 64'd0);
        check({tag, " result"}, {32'd0, data_result}, {32'd0, exp_res});
        check({tag, " exception"}, {63'd0, data_exception}, {63'd0, exp_exc});
        check({tag, " out_IR"}, {32'd0, out_IR}, {32'd0, exp_ir});
        check({tag, " busy_in_done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op(input string tag, input bit is_mul, input logic [31:0] a,
                          input logic [31:0] b);
        start_op(is_mul, a, b, $urandom);
        wait_done(tag, 0);
        tick();
        check({tag, " idle_rdy"}, {63'd0, data_resultRDY}, 64'd0);
        check({tag, " held"}, {32'd0, data_result}, {32'd0, exp_res});
    endtask

    initial begin
        int pulses;
        bit chain;
        logic [31:0] a, b;

        rst_n = 1'b0;
        repeat (3) tick();
        check("rst result", {32'd0, data_result}, 64'd0);
        check("rst exception", {63'd0, data_exception}, 64'd0);
        check("rst rdy", {63'd0, data_resultRDY}, 64'd0);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst out_IR", {32'd0, out_IR}, 64'd0);
        rst_n = 1'b1;
        tick();

        run_op("mul 7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD);
        run_op("mul ovf", 1'b1, 32'h0001_0000, 32'h0001_0000);
        run_op("mul -1x-1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000);
        run_op("div -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        run_op("div 5/0", 1'b0, 32'd5, 32'd0);
        run_op("div min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div min/1", 1'b0, 32'h8000_0000, 32'd1);

        // Stray start during DIV is ignored; back-to-back MULT launched from DONE.
        start_op(1'b0, 32'd1000, 32'hFFFF_FFF9, 32'hD1D1_0001);
        wait_done("b2b div", 5);
        start_op(1'b1, 32'd12345, 32'hFFFF_0000, 32'hA5A5_0002);
        wait_done("b2b mul", 0);
        tick();

        // Randomized mix, roughly half chained back-to-back out of DONE.
        chain = 1'b0;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom_range(1, 15);
                4: b = -$urandom_range(1, 15);
                default: ;
            endcase
            start_op($urandom_range(0, 1) == 1, a, b, $urandom);
            wait_done($sformatf("rnd%0d", i), 0);
            chain = ($urandom_range(0, 1) == 1);
            if (!chain) tick();
        end
        if (chain) tick();

        // Abort a multiply with reset in its 8th busy cycle.
        start_op(1'b1, 32'h1234_5678, 32'h0000_0ABC, 32'hBEEF_0003);
        tick();
        ctrl_MULT = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort result", {32'd0, data_result}, 64'd0);
        check("abort out_IR", {32'd0, out_IR}, 64'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            tick();
            if (data_resultRDY) pulses++;
        end
        check("abort no_pulse", 64'(pulses), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
